mac_pe: RTL and testbench

Processing element directly downstream of the instruction-sequencing control unit. It consumes the per-beat valid/last strobe and one operand pair per beat. It accumulates the signed products of one calc group and presents the group result on a valid/ready output port. The result is held until a consumer (writeback/output buffer) accepts it.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/sat_add.sv | 37 +++
 rtl/mac_pe.sv | 130 +++++++++++++
 tb/tb_mac_pe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the mac_pe processing element.
//   pe_state_t       : group-sequencing state of the PE
//   PE_*_WIDTH       : default widths used when the PE is instantiated bare
//   sat_max/sat_min  : signed limits of a given width, returned as 64-bit
//                      patterns whose low w bits are the limit value
package pe_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} pe_state_t;

    localparam int PE_DATA_WIDTH = 8;
    localparam int PE_ACC_WIDTH  = 32;
    localparam int PE_CNT_WIDTH  = 8;

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Sign-extended over 64 bits, so any low slice of width w is the minimum.
    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder with overflow detection.
//   a, b      : signed addends, ACC_WIDTH bits
//   sum       : a + b, clamped to the signed range when SATURATE=1,
//               plain two's-complement wrap when SATURATE=0
module sat_add
    import pe_pkg::*;
#(
    parameter int ACC_WIDTH = PE_ACC_WIDTH,
    parameter bit SATURATE  = 1'b1
) (
    input  logic signed [ACC_WIDTH-1:0] a,
    input  logic signed [ACC_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0] sum
);

    localparam logic [63:0] MAX64 = sat_max(ACC_WIDTH);
    localparam logic [63:0] MIN64 = sat_min(ACC_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0] MAXV = MAX64[ACC_WIDTH-1:0];
    localparam logic signed [ACC_WIDTH-1:0] MINV = MIN64[ACC_WIDTH-1:0];

    logic signed [ACC_WIDTH-1:0] raw;
    logic                        ovf;

    assign raw = a + b;
    // Overflow only when both addends share a sign and the result flips it;
    // the addend sign then tells which rail was crossed.
    assign ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) &&
                 (raw[ACC_WIDTH-1] != a[ACC_WIDTH-1]);

    always_comb begin
        sum = raw;
        if (SATURATE && ovf) begin
            sum = a[ACC_WIDTH-1] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/mac_pe.sv
// Multiply-accumulate processing element. Accumulates signed a_in*b_in over
// one group of beats (closed by in_last) and holds the group sum on a
// valid/ready output until the consumer accepts it.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_last   : beat strobe and end-of-group marker
//   a_in, b_in          : signed operands, sampled with in_valid
//   in_ready            : beat accepted when in_valid && in_ready
//   out_valid/out_ready : result handshake
//   out_data, out_count : group sum and number of beats in the group
//   err_drop, clr_err   : sticky dropped-beat flag and its clear
module mac_pe
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH,
    parameter int CNT_WIDTH  = PE_CNT_WIDTH,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    output logic        [CNT_WIDTH-1:0]  out_count,
    output logic                         err_drop,
    input  logic                         clr_err
);

    pe_state_t                     state, state_next;
    logic signed [ACC_WIDTH-1:0]   acc, acc_next;
    logic        [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic signed [ACC_WIDTH-1:0]   res, res_next;
    logic        [CNT_WIDTH-1:0]   res_cnt, res_cnt_next;
    logic                          err, err_next;

    logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext, base, sum;
    logic        [CNT_WIDTH-1:0]    cnt_base, cnt_inc;
    logic                           accept;

    assign out_valid = (state == S_OUT);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_data  = res;
    assign out_count = res_cnt;
    assign err_drop  = err;

    assign a_ext    = (2*DATA_WIDTH)'(a_in);
    assign b_ext    = (2*DATA_WIDTH)'(b_in);
    assign prod     = a_ext * b_ext;
    assign prod_ext = ACC_WIDTH'(prod);

    // Only S_ACCUM carries a partial sum; a beat taken in S_IDLE or during
    // the hold cycle of S_OUT starts a fresh group from zero.
    assign base     = (state == S_ACCUM) ? acc : '0;
    assign cnt_base = (state == S_ACCUM) ? cnt : '0;
    assign cnt_inc  = cnt_base + CNT_WIDTH'(1);

    sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_add (
        .a   (base),
        .b   (prod_ext),
        .sum (sum)
    );

    always_comb begin
        state_next   = state;
        acc_next     = acc;
        cnt_next     = cnt;
        res_next     = res;
        res_cnt_next = res_cnt;
        err_next     = err;

        case (state)
            S_OUT: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            if (in_last) begin
                res_next     = sum;
                res_cnt_next = cnt_inc;
                acc_next     = '0;
                cnt_next     = '0;
                state_next   = S_OUT;
            end else begin
                acc_next   = sum;
                cnt_next   = cnt_inc;
                state_next = S_ACCUM;
            end
        end

        // A drop in the same cycle as clr_err keeps the flag set.
        if (in_valid && !in_ready) begin
            err_next = 1'b1;
        end else if (clr_err) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            cnt     <= '0;
            res     <= '0;
            res_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            res     <= res_next;
            res_cnt <= res_cnt_next;
            err     <= err_next;
        end
    end

endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: three instances (32-bit saturating, 16-bit saturating,
// 16-bit wrapping) share one stimulus stream; a group-level model predicts
// every output after each clock.
module tb_mac_pe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic signed [7:0] a = '0;
    logic signed [7:0] b = '0;
    logic              out_ready = 1'b1;
    logic              clr_err = 1'b0;

    logic               ir32, ov32, er32;
    logic signed [31:0] od32;
    logic [7:0]         oc32;
    logic               ir16s, ov16s, er16s;
    logic signed [15:0] od16s;
    logic [7:0]         oc16s;
    logic               ir16w, ov16w, er16w;
    logic signed [15:0] od16w;
    logic [7:0]         oc16w;

    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .CNT_WIDTH(8), .SATURATE(1'b1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .a_in(a), .b_in(b), .in_ready(ir32), .out_valid(ov32),
        .out_ready(out_ready), .out_data(od32), .out_count(oc32),
        .err_drop(er32), .clr_err(clr_err));

    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .SATURATE(1'b1)) dut16s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .a_in(a), .b_in(b), .in_ready(ir16s), .out_valid(ov16s),
        .out_ready(out_ready), .out_data(od16s), .out_count(oc16s),
        .err_drop(er16s), .clr_err(clr_err));

    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8), .SATURATE(1'b0)) dut16w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .a_in(a), .b_in(b), .in_ready(ir16w), .out_valid(ov16w),
        .out_ready(out_ready), .out_data(od16w), .out_count(oc16w),
        .err_drop(er16w), .clr_err(clr_err));

    int total = 0;
    int bad   = 0;

    // Model: a partial group sum per instance flavour plus a pending result.
    int     wid [3] = '{32, 16, 16};
    bit     sat [3] = '{1'b1, 1'b1, 1'b0};
    bit     m_busy = 0;
    longint m_acc [3] = '{0, 0, 0};
    int     m_cnt = 0;
    bit     m_ov = 0;
    longint m_od [3] = '{0, 0, 0};
    int     m_oc = 0;
    bit     m_err = 0;

    function automatic longint fit(input longint v, input int w, input bit s);
        longint mx, mn, m;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        if (s) begin
            if (v > mx) return mx;
            if (v < mn) return mn;
            return v;
        end
        m = longint'(1) <<< w;
        v = v & (m - 1);
        if (v > mx) v = v - m;
        return v;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        longint rdy;
        rdy = (!m_ov || out_ready) ? 1 : 0;
        chk("in_ready",   longint'(ir32), rdy);
        chk("out_valid",  longint'(ov32), longint'(m_ov));
        chk("out_data32", longint'(od32), m_od[0]);
        chk("out_count",  longint'(oc32), longint'(m_oc));
        chk("err_drop",   longint'(er32), longint'(m_err));
        chk("out_data16s", longint'(od16s), m_od[1]);
        chk("out_data16w", longint'(od16w), m_od[2]);
        chk("out_valid16", longint'({ov16s, ov16w}), longint'({m_ov, m_ov}));
        chk("in_ready16",  longint'({ir16s, ir16w}), longint'({rdy[0], rdy[0]}));
        chk("misc16", longint'({oc16s, oc16w, er16s, er16w}),
            longint'({m_oc[7:0], m_oc[7:0], m_err, m_err}));
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then compare all outputs just after the edge.
    task automatic tick();
        bit     rdy, take, drop;
        int     c;
        longint s;
        rdy = !m_ov || out_ready;
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_ov = 0; m_oc = 0; m_err = 0;
            for (int k = 0; k < 3; k++) begin m_acc[k] = 0; m_od[k] = 0; end
        end else begin
            take = in_valid && rdy;
            drop = in_valid && !rdy;
            if (m_ov && out_ready) m_ov = 0;
            if (take) begin
                c = ((m_busy ? m_cnt : 0) + 1) % 256;
                for (int k = 0; k < 3; k++) begin
                    s = fit((m_busy ? m_acc[k] : 0) + longint'(a) * longint'(b), wid[k], sat[k]);
                    if (in_last) begin m_od[k] = s; m_acc[k] = 0; end
                    else m_acc[k] = s;
                end
                if (in_last) begin
                    m_oc = c; m_ov = 1; m_busy = 0; m_cnt = 0;
                end else begin
                    m_cnt = c; m_busy = 1;
                end
            end
            if (drop) m_err = 1;
            else if (clr_err) m_err = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic beat(input int av, input int bv, input bit l);
        in_valid = 1'b1; in_last = l; a = 8'(av); b = 8'(bv);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", longint'(ov32), 0);
        chk("rst_out_data",  longint'(od32), 0);
        chk("rst_in_ready",  longint'(ir32), 1);

        // Four-beat group, sum 40
        out_ready = 1'b1;
        beat(1, 2, 0); beat(3, 4, 0); beat(-5, 6, 0); beat(7, 8, 1);
        chk("g4_valid", longint'(ov32), 1);
        chk("g4_data",  longint'(od32), 40);
        chk("g4_count", longint'(oc32), 4);
        tick();
        chk("g4_valid_drop", longint'(ov32), 0);

        // Single-beat group
        beat(-3, 9, 1);
        chk("g1_data",  longint'(od32), -27);
        chk("g1_count", longint'(oc32), 1);
        tick();
        chk("g1_one_cycle", longint'(ov32), 0);

        // Backpressure and drop
        out_ready = 1'b0;
        beat(2, 3, 0); beat(4, 1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", longint'(od32), 10);
            chk("bp_in_ready",  longint'(ir32), 0);
        end
        beat(5, 5, 0);
        chk("bp_err",  longint'(er32), 1);
        chk("bp_data", longint'(od32), 10);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", longint'(ir32), 1);
        tick();
        chk("bp_released", longint'(ov32), 0);
        chk("bp_err_sticky", longint'(er32), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("bp_err_clear", longint'(er32), 0);

        // Saturation and wrap
        beat(127, 127, 0); beat(127, 127, 0); beat(127, 127, 1);
        chk("sat_hi_32",  longint'(od32),  48387);
        chk("sat_hi_16s", longint'(od16s), 32767);
        chk("sat_hi_16w", longint'(od16w), -17149);
        beat(127, -128, 0); beat(127, -128, 0); beat(127, -128, 1);
        chk("sat_lo_16s", longint'(od16s), -32768);
        chk("sat_lo_16w", longint'(od16w), 16768);
        beat(127, 127, 0); beat(127, 127, 0); beat(127, 127, 0); beat(-128, 127, 1);
        chk("sat_back_16s", longint'(od16s), 16511);
        chk("sat_back_16w", longint'(od16w), 32131);
        chk("sat_back_32",  longint'(od32),  32131);
        tick();

        // Back-to-back groups without a bubble
        out_ready = 1'b0;
        beat(1, 1, 1);
        tick();
        out_ready = 1'b1;
        beat(2, 2, 0);
        chk("b2b_accum_valid", longint'(ov32), 0);
        beat(2, 2, 1);
        chk("b2b_data",  longint'(od32), 8);
        chk("b2b_count", longint'(oc32), 2);
        beat(3, 3, 1);
        chk("b2b_single_valid", longint'(ov32), 1);
        chk("b2b_single_data",  longint'(od32), 9);
        tick();

        // Reset mid-group
        beat(5, 5, 0); beat(6, 6, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", longint'(ov32), 0);
        chk("mid_rst_count", longint'(oc32), 0);
        beat(1, 1, 1);
        chk("post_rst_data",  longint'(od32), 1);
        chk("post_rst_count", longint'(oc32), 1);
        tick();

        // Beat counter wrap: 257 beats
        for (int i = 0; i < 256; i++) beat(1, 1, 0);
        beat(1, 1, 1);
        chk("wrap_count", longint'(oc32), 1);
        chk("wrap_data",  longint'(od32), 257);
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            in_valid  = ($urandom_range(0, 99) < 60);
            in_last   = ($urandom_range(0, 99) < 25);
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            clr_err   = ($urandom_range(0, 99) < 10);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
